// File: rtl/ram8_bank16_if.sv
// ram8_bank16_if: write/read/clear bus of the eight-word register bank; parity pins exist only with RAM8_PARITY_EN.
interface ram8_bank16_if #(parameter int WIDTH = 16);
  logic             wr_valid;
  logic             wr_ready;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [2:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             clr_req;
  logic             busy;
  logic [7:0]       word_valid;
`ifdef RAM8_PARITY_EN
  logic             par_inj;
  logic             rd_perr;
`endif
  modport slave (
`ifdef RAM8_PARITY_EN
    input par_inj, output rd_perr,
`endif
    input wr_valid, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    output wr_ready, rd_data, rd_valid, busy, word_valid
  );
  modport master (
`ifdef RAM8_PARITY_EN
    output par_inj, input rd_perr,
`endif
    output wr_valid, wr_addr, wr_data, rd_en, rd_addr, clr_req,
    input wr_ready, rd_data, rd_valid, busy, word_valid
  );
endinterface

// File: rtl/ram8_bank16.sv
// ram8_bank16: 8x16 register bank with write handshake, 1-cycle registered read and sequenced clear-all.
// Optional macro RAM8_PARITY_EN adds a stored even-parity bit, par_inj and rd_perr.
module ram8_bank16 #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  ram8_bank16_if.slave bus
);
  localparam int DEPTH = 8;
`ifdef RAM8_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t r_state, w_next;
  logic [2:0]       r_ptr;
  logic [MW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_wv, w_we;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             w_idle, w_wr_ready, w_wr_en, w_rd_en;
  logic [MW-1:0]    w_wword, w_rword;
  assign w_idle     = r_state == IDLE;
  assign w_wr_ready = w_idle && !bus.clr_req;
  assign w_wr_en    = bus.wr_valid && w_wr_ready;
  assign w_rd_en    = w_idle && bus.rd_en;
  assign w_we       = w_wr_en ? DEPTH'(1) << bus.wr_addr : '0;
`ifdef RAM8_PARITY_EN
  logic r_rd_perr;
  assign w_wword     = {^bus.wr_data ^ bus.par_inj, bus.wr_data};
  assign bus.rd_perr = r_rd_perr;
`else
  assign w_wword = bus.wr_data;
`endif
  // write-first bypass when reading the word being written on the same edge
  assign w_rword = (w_wr_en && bus.wr_addr == bus.rd_addr) ? w_wword : r_mem[bus.rd_addr];
  assign bus.wr_ready   = w_wr_ready;
  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.busy       = !w_idle;
  assign bus.word_valid = r_wv;
  always_comb begin
    w_next = r_state;
    w_next = w_idle ? (bus.clr_req ? CLEAR : IDLE) : (r_ptr == 3'd7 ? IDLE : CLEAR);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wv       <= '0;
      r_ptr      <= 3'd0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
`ifdef RAM8_PARITY_EN
      r_rd_perr  <= 1'b0;
`endif
    end else begin
      r_ptr      <= w_idle ? 3'd0 : r_ptr + 3'd1;
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= w_rword[WIDTH-1:0];
`ifdef RAM8_PARITY_EN
        r_rd_perr <= ^w_rword;
`endif
      end
      for (int i = 0; i < DEPTH; i++)
        if (w_we[i]) r_mem[i] <= w_wword;
        else if (!w_idle && r_ptr == 3'(i)) r_mem[i] <= '0;
      r_wv <= w_idle ? (r_wv | w_we) : (r_wv & ~(DEPTH'(1) << r_ptr));
    end
  end
endmodule

// File: tb/tb_ram8_bank16.sv
// tb_ram8_bank16: directed self-checking bench for ram8_bank16 (parity checks run when RAM8_PARITY_EN is defined).
module tb_ram8_bank16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int n;
  ram8_bank16_if #(.WIDTH(16)) bus ();
  ram8_bank16 #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [2:0] a, input logic [15:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask
  task automatic read_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en = 1'b0;
    chk({tag, "_v"}, 32'(bus.rd_valid), 32'd1);
    chk({tag, "_d"}, 32'(bus.rd_data), 32'(exp));
  endtask
  task automatic wait_idle;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
  endtask
  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.clr_req  = 1'b0;
`ifdef RAM8_PARITY_EN
    bus.par_inj  = 1'b0;
`endif
    #2;
    chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_word_valid", 32'(bus.word_valid), 32'h0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
    #20 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) write(3'(i), 16'(16'h1111 * (i + 1)));
    chk("fill_word_valid", 32'(bus.word_valid), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = 3'(i);
      tick();
      chk($sformatf("b2b_v%0d", i), 32'(bus.rd_valid), 32'd1);
      chk($sformatf("b2b_d%0d", i), 32'(bus.rd_data), 32'(16'h1111 * (i + 1)));
    end
    bus.rd_en = 1'b0;
    tick();
    chk("rd_pulse_end", 32'(bus.rd_valid), 32'd0);
    chk("rd_hold", 32'(bus.rd_data), 32'h8888);
    bus.rd_en = 1'b1;
    bus.rd_addr = 3'd3;
    write(3'd3, 16'hA5A5);
    bus.rd_en = 1'b0;
    chk("wf_same", 32'(bus.rd_data), 32'hA5A5);
    bus.rd_en = 1'b1;
    bus.rd_addr = 3'd4;
    write(3'd3, 16'h5A5A);
    bus.rd_en = 1'b0;
    chk("wf_other", 32'(bus.rd_data), 32'h5555);
    read_chk("rd3_new", 3'd3, 16'h5A5A);
    bus.clr_req  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = 16'hBEEF;
    #1;
    chk("clr_wr_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    bus.clr_req  = 1'b0;
    bus.wr_valid = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      bus.rd_en = 1'b1;
      tick();
      n++;
      chk("clr_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    bus.rd_en = 1'b0;
    chk("clr_busy_cycles", 32'(n), 32'd8);
    chk("clr_word_valid", 32'(bus.word_valid), 32'h00);
    for (int i = 0; i < 8; i++) read_chk($sformatf("clr_rd%0d", i), 3'(i), 16'h0000);
    write(3'd6, 16'hDEF0);
    read_chk("pre_rst_rd6", 3'd6, 16'hDEF0);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_word_valid", 32'(bus.word_valid), 32'h40);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_word_valid", 32'(bus.word_valid), 32'h00);
    chk("arst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("arst_wr_ready", 32'(bus.wr_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();
    read_chk("post_rst_rd6", 3'd6, 16'h0000);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 3'd5;
    bus.wr_data  = 16'h1234;
    bus.clr_req  = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    wait_idle();
    chk("hold_busy_cycles", 32'(n), 32'd8);
    chk("hold_wv_before", 32'(bus.word_valid), 32'h00);
    chk("hold_wr_ready", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_valid = 1'b0;
    chk("hold_wv_after", 32'(bus.word_valid), 32'h20);
    read_chk("hold_rd5", 3'd5, 16'h1234);
`ifdef RAM8_PARITY_EN
    bus.par_inj = 1'b1;
    write(3'd2, 16'h0001);
    bus.par_inj = 1'b0;
    read_chk("par_rd_inj", 3'd2, 16'h0001);
    chk("par_perr_inj", 32'(bus.rd_perr), 32'd1);
    write(3'd2, 16'h0001);
    read_chk("par_rd_ok", 3'd2, 16'h0001);
    chk("par_perr_ok", 32'(bus.rd_perr), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
